// File: rtl/led_sequencer_ctrl.sv
// LED bank sequencer: prescaled step timebase, mode-driven pattern generator
// (static/blink/scan/count/rotate) and global PWM dimming behind a small register file.
module led_sequencer_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned N_LEDS   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              step,
  output logic [N_LEDS-1:0] leds
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  typedef enum logic { IDLE, RUN } seq_state_t;

  typedef enum logic [2:0] {
    M_OFF    = 3'd0,
    M_STATIC = 3'd1,
    M_BLINK  = 3'd2,
    M_SCAN   = 3'd3,
    M_COUNT  = 3'd4,
    M_ROTATE = 3'd5
  } mode_t;

  logic [2:0]        mode;
  logic              enable;
  logic [15:0]       period;
  logic [N_LEDS-1:0] pattern;
  logic [7:0]        duty;

  logic [PRE_W-1:0]  pre;
  logic [15:0]       step_cnt;
  logic [7:0]        pwm_cnt;
  seq_state_t        state;

  logic              phase;
  logic [POS_W-1:0]  pos;
  logic              dir_down;
  logic [N_LEDS-1:0] cnt;
  logic [N_LEDS-1:0] rot;

  logic              tick;
  logic [15:0]       period_eff;
  logic              step_evt;
  logic              gate;
  logic              wr_ctrl;
  logic              wr_period;
  logic              wr_pattern;
  logic              wr_duty;
  logic [N_LEDS-1:0] raw;

  always_comb begin
    tick       = (pre == PRE_W'(TICK_DIV - 1));
    period_eff = (period == '0) ? 16'd1 : period;
    step_evt   = (state == RUN) && enable && tick &&
                 (({1'b0, step_cnt} + 17'd1) >= {1'b0, period_eff});
    gate       = (pwm_cnt < duty);
    wr_ctrl    = cfg_we && (cfg_addr == 2'd0);
    wr_period  = cfg_we && (cfg_addr == 2'd1);
    wr_pattern = cfg_we && (cfg_addr == 2'd2);
    wr_duty    = cfg_we && (cfg_addr == 2'd3);
  end

  always_comb begin
    raw = '0;
    if (state == RUN) begin
      case (mode)
        M_STATIC: raw = pattern;
        M_BLINK:  raw = phase ? pattern : '0;
        M_SCAN:   raw = N_LEDS'(1) << pos;
        M_COUNT:  raw = cnt;
        M_ROTATE: raw = rot;
        default:  raw = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode      <= '0;
      enable    <= 1'b0;
      period    <= '0;
      pattern   <= '0;
      duty      <= '0;
      pre       <= '0;
      step_cnt  <= '0;
      pwm_cnt   <= '0;
      state     <= IDLE;
      phase     <= 1'b0;
      pos       <= '0;
      dir_down  <= 1'b0;
      cnt       <= '0;
      rot       <= '0;
      step      <= 1'b0;
      leds      <= '0;
      cfg_rdata <= '0;
    end else begin
      pre     <= tick ? '0 : pre + PRE_W'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
      step    <= step_evt;
      leds    <= raw & {N_LEDS{gate}};

      case (cfg_addr)
        2'd0:    cfg_rdata <= {12'd0, enable, mode};
        2'd1:    cfg_rdata <= period;
        2'd2:    cfg_rdata <= 16'(pattern);
        default: cfg_rdata <= {8'd0, duty};
      endcase

      if (wr_ctrl) begin
        mode   <= cfg_wdata[2:0];
        enable <= cfg_wdata[3];
      end
      if (wr_period)  period  <= cfg_wdata;
      if (wr_pattern) pattern <= cfg_wdata[N_LEDS-1:0];
      if (wr_duty)    duty    <= cfg_wdata[7:0];

      case (state)
        IDLE: begin
          step_cnt <= '0;
          if (enable) state <= RUN;
        end
        default: begin
          if (!enable) begin
            state    <= IDLE;
            step_cnt <= '0;
          end else if (step_evt) begin
            step_cnt <= '0;
          end else if (tick) begin
            step_cnt <= step_cnt + 16'd1;
          end
          // A register write in the same clock wins; the step still pulses but does not advance state.
          if (step_evt && !cfg_we) begin
            case (mode)
              M_BLINK: phase <= ~phase;
              M_SCAN: begin
                if (!dir_down) begin
                  if (pos == POS_W'(N_LEDS - 1)) begin
                    pos      <= pos - POS_W'(1);
                    dir_down <= 1'b1;
                  end else begin
                    pos <= pos + POS_W'(1);
                  end
                end else begin
                  if (pos == '0) begin
                    pos      <= POS_W'(1);
                    dir_down <= 1'b0;
                  end else begin
                    pos <= pos - POS_W'(1);
                  end
                end
              end
              M_COUNT:  cnt <= cnt + N_LEDS'(1);
              M_ROTATE: rot <= {rot[N_LEDS-2:0], rot[N_LEDS-1]};
              default: ;
            endcase
          end
        end
      endcase

      if (wr_ctrl || wr_period) step_cnt <= '0;
      if (wr_ctrl) begin
        phase    <= 1'b1;
        pos      <= '0;
        dir_down <= 1'b0;
        cnt      <= '0;
        rot      <= pattern;
      end
      if (wr_pattern && (mode == M_ROTATE)) rot <= cfg_wdata[N_LEDS-1:0];
    end
  end

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Scoreboard bench for led_sequencer_ctrl: stimulus queues expected LED patterns,
// a monitor pops and compares them on every step pulse.
module tb_led_sequencer_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        step;
  logic [7:0]  leds;

  led_sequencer_ctrl #(.TICK_DIV(4), .N_LEDS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .step      (step),
    .leds      (leds)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int step_times[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (step) step_times.push_back(cyc);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: LEDs settle one clock after the step pulse; OR two samples to hide the single PWM-off clock.
  initial begin
    logic [7:0] a;
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (mon_en && step) begin
        @(negedge clock) a = leds;
        @(negedge clock) b = leds;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_step: leds 0x%0h with no expected value queued", a | b);
        end else begin
          check("step_leds", a | b, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [15:0] e);
    @(negedge clock);
    cfg_addr = a;
    @(negedge clock);
    check(name, cfg_rdata, e);
  endtask

  task automatic sample_or(output logic [7:0] v);
    logic [7:0] a;
    @(negedge clock) a = leds;
    @(negedge clock) v = a | leds;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s: timeout with %0d expected patterns outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_step(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!step && n < limit);
    if (!step) begin
      checks++;
      fails++;
      $display("FAIL %s: no step within %0d cycles, required a step pulse", name, limit);
    end
  endtask

  task automatic count_lit(input logic [7:0] pat, input int cycles, output int lit, output int other);
    lit = 0; other = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (leds == pat) lit++;
      else if (leds != 8'h00) other++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int lit, other, c, d;

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_leds", leds, 8'h00);
    check("reset_rdata", cfg_rdata, 16'h0000);
    check("reset_step", step, 1'b0);
    step_times.delete();
    repeat (40) @(negedge clock);
    check("no_step_while_disabled", 16'(step_times.size()), 16'd0);

    // BLINK, register readback with RAZ/WI bits
    wr(2'd1, 16'd2);
    wr(2'd2, 16'hFFA5);
    wr(2'd3, 16'h12FF);
    rd_check("rd_period", 2'd1, 16'h0002);
    rd_check("rd_pattern", 2'd2, 16'h00A5);
    rd_check("rd_duty", 2'd3, 16'h00FF);
    step_times.delete();
    wr(2'd0, 16'hFFFA);
    @(negedge clock);
    sample_or(v);
    check("blink_initial", v, 8'hA5);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
    mon_en = 1'b1;
    drain("blink_drain", 200);
    mon_en = 1'b0;
    if (step_times.size() < 4) begin
      checks++; fails++;
      $display("FAIL blink_step_count: got %0d steps, required at least 4", step_times.size());
    end else begin
      for (int i = 1; i < 4; i++)
        check("blink_step_interval", 16'(step_times[i] - step_times[i-1]), 16'd8);
    end
    rd_check("rd_ctrl", 2'd0, 16'h000A);

    // SCAN, bouncing one-hot
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'd1);
    foreach (v[i]) ;
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h40);
    exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'h20);
    exp_q.push_back(8'h10); exp_q.push_back(8'h08); exp_q.push_back(8'h04);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    wr(2'd0, 16'h000B);
    mon_en = 1'b1;
    drain("scan_drain", 400);
    mon_en = 1'b0;

    // COUNT across the all-ones wrap, then CTRL rewrite mid-run
    wr(2'd0, 16'h0000);
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    wr(2'd0, 16'h000C);
    mon_en = 1'b1;
    drain("count_drain", 3000);
    mon_en = 1'b0;
    wr(2'd1, 16'd5);
    wait_step("count_wait1", 100);
    wait_step("count_wait2", 100);
    repeat (5) @(negedge clock);
    wr(2'd0, 16'h000C);
    c = cyc;
    step_times.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    mon_en = 1'b1;
    drain("count_restart_drain", 200);
    mon_en = 1'b0;
    checks++;
    d = (step_times.size() > 0) ? step_times[0] - c : -1;
    if (d < 17 || d > 20) begin
      fails++;
      $display("FAIL count_restart_delay: got %0d cycles to first step, required 17..20", d);
    end

    // ROTATE, with a PATTERN write landing on a step clock
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'd1);
    wr(2'd2, 16'h0081);
    exp_q.push_back(8'h03); exp_q.push_back(8'h06);
    wr(2'd0, 16'h000D);
    mon_en = 1'b1;
    drain("rot_drain", 100);
    mon_en = 1'b0;
    wait_step("rot_align", 50);
    repeat (2) @(negedge clock);
    wr(2'd2, 16'h0010);
    check("rot_write_step_pulse", step, 1'b1);
    sample_or(v);
    check("rot_reload", v, 8'h10);
    exp_q.push_back(8'h20); exp_q.push_back(8'h40);
    mon_en = 1'b1;
    drain("rot_drain2", 100);
    mon_en = 1'b0;
    rd_check("rd_pattern2", 2'd2, 16'h0010);

    // STATIC with PWM dimming and enable toggling
    wr(2'd0, 16'h0000);
    wr(2'd2, 16'h00FF);
    wr(2'd3, 16'd64);
    wr(2'd0, 16'h0009);
    repeat (4) @(negedge clock);
    count_lit(8'hFF, 256, lit, other);
    check("pwm64_on", 16'(lit), 16'd64);
    check("pwm64_other", 16'(other), 16'd0);
    wr(2'd3, 16'd0);
    repeat (3) @(negedge clock);
    count_lit(8'hFF, 256, lit, other);
    check("pwm0_on", 16'(lit), 16'd0);
    wr(2'd3, 16'd255);
    repeat (3) @(negedge clock);
    count_lit(8'hFF, 256, lit, other);
    check("pwm255_on", 16'(lit), 16'd255);
    wr(2'd0, 16'h0001);
    repeat (3) @(negedge clock);
    count_lit(8'hFF, 32, lit, other);
    check("disabled_dark", 16'(lit + other), 16'd0);
    rd_check("rd_ctrl_dis", 2'd0, 16'h0001);
    wr(2'd0, 16'h0009);
    repeat (2) @(negedge clock);
    sample_or(v);
    check("reenable_static", v, 8'hFF);

    // Reset mid-operation
    cfg_addr = 2'd3;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_leds", leds, 8'h00);
    check("midreset_rdata", cfg_rdata, 16'h0000);
    rd_check("midreset_duty", 2'd3, 16'h0000);
    rd_check("midreset_ctrl", 2'd0, 16'h0000);
    step_times.delete();
    repeat (40) @(negedge clock);
    check("midreset_no_step", 16'(step_times.size()), 16'd0);
    check("midreset_leds_hold", leds, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/led_sequencer_ctrl.md
Name: led_sequencer_ctrl

Overview:
Register-configured controller that sequences the DE0-Nano user LED bank. Replaces per-LED free-running blinkers with one prescaled timebase, a mode-driven pattern generator (static, blink, scan, count, rotate) and global PWM dimming. Sits between the NIOS II PIO/config bus and the LED pins.

Parameters:
TICK_DIV, 50000, clocks per base tick (50 MHz -> 1 kHz tick); legal range 2..2^20
N_LEDS, 8, LED count; pattern, scan and count logic sized to N_LEDS; rdata pattern field holds N_LEDS <= 16

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cfg_we  in  1  register write strobe, one cycle per write
cfg_addr  in  2  register address
cfg_wdata  in  16  write data
cfg_rdata  out  16  read data for cfg_addr, registered, 1-cycle latency
step  out  1  one-cycle pulse on each sequencer step (debug/IRQ)
leds  out  N_LEDS  LED drive, registered, 1 = lit

Behaviour:
- Reset: all registers 0, leds=0, cfg_rdata=0, step=0, prescaler/step counter/PWM counter 0, seq state IDLE.
- Register map:
  0 CTRL: [2:0] mode, [3] enable, rest RAZ/WI
  1 PERIOD: [15:0] ticks per step; 0 treated as 1
  2 PATTERN: [N_LEDS-1:0] base pattern
  3 DUTY: [7:0] PWM duty
- cfg_rdata: registered read of addr valid one cycle after the address is presented, for every cycle (not gated by cfg_we).
- Prescaler: counts 0..TICK_DIV-1; tick=1 for one clock on wrap. Runs always, including when enable=0.
- Step counter: counts ticks; on reaching PERIOD (or 1 if PERIOD=0) -> step=1 for one clock, counter clears.
- Seq state machine:
  IDLE: enable=0; state frozen (phase/pos/cnt/rot held), step counter held at 0, raw=0. -> RUN when enable=1.
  RUN: advances on step. -> IDLE when enable=0.
- Modes (raw pattern in RUN):
  0 OFF: 0
  1 STATIC: PATTERN
  2 BLINK: PATTERN when phase=1 else 0; phase toggles each step; phase=1 after mode load
  3 SCAN: one-hot at pos; pos bounces 0->N_LEDS-1->0, direction flips at ends, each end shown once per pass (0,1,..,7,6,..,1,0,...)
  4 COUNT: binary cnt, +1 per step, wraps all-ones -> 0
  5 ROTATE: rot loaded from PATTERN, rotates left by 1 per step (MSB -> LSB)
  6,7 reserved: behave as OFF
- Mode load: any CTRL write (mode changed or not) clears step counter, sets phase=1, pos=0, dir=up, cnt=0, rot=PATTERN.
- PATTERN write in ROTATE: rot reloaded from new value. PERIOD write clears step counter.
- Write and step in same clock: write takes effect, step's state advance discarded; step output still pulses.
- PWM: 8-bit free-running counter per clock; gate = (pwm_cnt < DUTY). DUTY=0 -> always off; DUTY=255 -> on 255 of 256 clocks.
- leds <= raw & {N_LEDS{gate}}; one clock from internal state/pwm change to pin.
- Reset mid-operation: immediate return to reset values on next clock edge, regardless of mode.

Test Plan:
- Reset with TICK_DIV=4: after reset, leds=0, cfg_rdata=0, step never asserted while CTRL=0.
- TICK_DIV=4, PERIOD=2, PATTERN=0xA5, DUTY=255, CTRL=0x0A (BLINK, en): leds=0xA5 (except PWM-off clock), step every 8 clocks, leds alternate 0xA5/0x00 each step.
- SCAN, PERIOD=1: leds sequence 0x01,0x02,..,0x80,0x40,..,0x01,0x02; no repeat at ends.
- COUNT with cnt forced near wrap via 255 steps: 0xFF -> 0x00 on next step; CTRL rewrite mid-run resets to 0x00 and step counter.
- ROTATE PATTERN=0x81: 0x81 -> 0x03 -> 0x06; write PATTERN=0x10 on a step clock -> leds 0x10, no advance that cycle.
- STATIC 0xFF, DUTY=64: over 256 clocks leds=0xFF exactly 64 clocks; DUTY=0 -> always 0; enable=0 -> leds 0, state resumes unchanged on re-enable.
